// File: rtl/rv_fetch_wb_master_if.sv
// Wishbone-classic instruction-read bus between the fetch master and its memory slave.
interface rv_fetch_wb_master_if;
   logic        cyc;
   logic        stb;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat;
   logic        ack;
   logic        err;

   modport master (
      output cyc, stb, adr, sel,
      input  dat, ack, err
   );

   modport slave (
      input  cyc, stb, adr, sel,
      output dat, ack, err
   );
endinterface

// File: rtl/rv_fetch_wb_master.sv
// Fetch-side Wishbone master: one single-word read per request, with flush/discard,
// sticky bus-error flag and a no-ack watchdog.
module rv_fetch_wb_master #(
   parameter  int TIMEOUT_CYCLES = 16,
   localparam int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic [31:0]  i_addr,
   input  logic         i_req,
   input  logic         i_flush,
   output logic [31:0]  o_instruction,
   output logic         o_data_latch,
   output logic         o_pc_inc,
   output logic         o_busy,
   output logic         o_err,
   rv_fetch_wb_master_if.master wb
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]           r_state;
   logic                 r_cyc;
   logic [31:0]          r_adr;
   logic [TIMEOUT_W-1:0] r_cnt;
   logic                 r_err;

   logic                 w_timeout;
   logic [TIMEOUT_W-1:0] w_cnt_next;
   logic                 w_deliver;

   assign w_timeout  = (r_cnt == CNT_LAST);
   assign w_cnt_next = w_timeout ? r_cnt : r_cnt + 1'b1;

   // NOTE: the word is handed over combinationally in the ack cycle; a registered
   // strobe would cost a cycle and arrive after the fetch PC had already moved.
   assign w_deliver = (r_state == S_REQ) & wb.ack & ~wb.err & ~i_flush;

   assign o_instruction = wb.dat;
   assign o_data_latch  = w_deliver;
   assign o_pc_inc      = w_deliver;
   assign o_busy        = (r_state != S_IDLE);
   assign o_err         = r_err;

   assign wb.cyc = r_cyc;
   assign wb.stb = r_cyc;
   assign wb.adr = r_adr;
   assign wb.sel = 4'hF;

   // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cyc   <= 1'b0;
         r_adr   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // A redirect cycle never issues: i_addr still holds the old PC here.
               if (i_flush) begin
                  r_err <= 1'b0;
               end else if (i_req && !r_err) begin
                  r_adr   <= i_addr & ~32'd3;
                  r_cyc   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_REQ;
               end
            end

            S_REQ: begin
               if (wb.err) begin
                  r_cyc   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else if (wb.ack) begin
                  r_cyc   <= 1'b0;
                  r_state <= S_IDLE;
                  if (i_flush) begin
                     r_err <= 1'b0;
                  end
               end else if (i_flush) begin
                  // Bus cycle must complete; the outstanding word is dropped later.
                  r_err   <= 1'b0;
                  r_cnt   <= w_cnt_next;
                  r_state <= S_DISCARD;
               end else if (w_timeout) begin
                  r_cyc   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end

            S_DISCARD: begin
               if (wb.err || wb.ack) begin
                  r_cyc   <= 1'b0;
                  r_state <= S_IDLE;
                  if (wb.err) begin
                     r_err <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_cyc   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end

            default: begin
               r_cyc   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_fetch_wb_master.sv
// Directed bench for rv_fetch_wb_master: a cycle table for the main flows plus
// hand-written timeout and asynchronous-reset sequences.
module tb_rv_fetch_wb_master;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_addr;
   logic        i_req;
   logic        i_flush;
   logic [31:0] o_instruction;
   logic        o_data_latch;
   logic        o_pc_inc;
   logic        o_busy;
   logic        o_err;

   rv_fetch_wb_master_if wb ();

   rv_fetch_wb_master #(.TIMEOUT_CYCLES(16)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_addr        (i_addr),
      .i_req         (i_req),
      .i_flush       (i_flush),
      .o_instruction (o_instruction),
      .o_data_latch  (o_data_latch),
      .o_pc_inc      (o_pc_inc),
      .o_busy        (o_busy),
      .o_err         (o_err),
      .wb            (wb)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        req;
      logic        flush;
      logic [31:0] addr;
      logic        ack;
      logic        err;
      logic [31:0] dat;
      logic        e_cyc;
      logic [31:0] e_adr;
      logic        e_latch;
      logic        e_busy;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errs   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic add(input logic req, input logic flush, input logic [31:0] addr,
                      input logic ack, input logic err, input logic [31:0] dat,
                      input logic e_cyc, input logic [31:0] e_adr, input logic e_latch,
                      input logic e_busy, input logic e_err);
      vec_t v;
      v.req = req;  v.flush = flush;  v.addr = addr;  v.ack = ack;  v.err = err;
      v.dat = dat;  v.e_cyc = e_cyc;  v.e_adr = e_adr;  v.e_latch = e_latch;
      v.e_busy = e_busy;  v.e_err = e_err;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  cyc_cycles;
      bit  done;
      bit  saw;

      // Cycle table: req flush addr ack err dat | cyc adr latch busy err
      add(1,0,32'h000,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h000,1,0,32'h13,        1,32'h000,1,1,0);
      add(1,0,32'h004,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h004,1,0,32'h13,        1,32'h004,1,1,0);
      add(1,0,32'h008,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h008,1,0,32'h13,        1,32'h008,1,1,0);
      add(1,0,32'h100,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h100,0,0,32'h0,         1,32'h100,0,1,0);
      add(1,0,32'h100,0,0,32'h0,         1,32'h100,0,1,0);
      add(1,0,32'h100,0,0,32'h0,         1,32'h100,0,1,0);
      add(1,0,32'h100,1,0,32'hDEADBEEF,  1,32'h100,1,1,0);
      add(0,0,32'h104,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h104,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h104,0,0,32'h0,         1,32'h104,0,1,0);
      add(1,1,32'h104,0,0,32'h0,         1,32'h104,0,1,0);
      add(1,0,32'h200,0,0,32'h0,         1,32'h104,0,1,0);
      add(1,0,32'h200,1,0,32'h55,        1,32'h104,0,1,0);
      add(1,0,32'h200,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h200,1,0,32'h00200013,  1,32'h200,1,1,0);
      add(1,0,32'h204,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,1,32'h204,1,0,32'h77,        1,32'h204,0,1,0);
      add(1,0,32'h300,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h300,1,0,32'h99,        1,32'h300,1,1,0);
      add(0,0,32'h304,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h403,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h403,0,1,32'h0,         1,32'h400,0,1,0);
      add(1,0,32'h403,0,0,32'h0,         0,32'h000,0,0,1);
      add(1,1,32'h403,0,0,32'h0,         0,32'h000,0,0,1);
      add(1,0,32'h400,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h400,1,0,32'hA5,        1,32'h400,1,1,0);
      add(1,0,32'h404,0,0,32'h0,         0,32'h000,0,0,0);
      add(1,0,32'h404,1,1,32'h66,        1,32'h404,0,1,0);
      add(0,1,32'h404,0,0,32'h0,         0,32'h000,0,0,1);
      add(0,0,32'h404,0,0,32'h0,         0,32'h000,0,0,0);

      // Reset state, with a stray ack and request present.
      i_reset = 1'b1;  i_addr = 32'h0;  i_req = 1'b1;  i_flush = 1'b0;
      wb.ack = 1'b1;  wb.err = 1'b0;  wb.dat = 32'h13;
      repeat (2) @(posedge i_clk);
      #3;
      check("reset cyc",   wb.cyc,       0);
      check("reset stb",   wb.stb,       0);
      check("reset adr",   wb.adr,       0);
      check("reset sel",   wb.sel,       4'hF);
      check("reset latch", o_data_latch, 0);
      check("reset pcinc", o_pc_inc,     0);
      check("reset busy",  o_busy,       0);
      check("reset err",   o_err,        0);
      step();
      i_reset = 1'b0;

      foreach (vecs[i]) begin
         i_req = vecs[i].req;  i_flush = vecs[i].flush;  i_addr = vecs[i].addr;
         wb.ack = vecs[i].ack;  wb.err = vecs[i].err;  wb.dat = vecs[i].dat;
         #2;
         check($sformatf("v%0d cyc", i),   wb.cyc,       vecs[i].e_cyc);
         check($sformatf("v%0d stb", i),   wb.stb,       vecs[i].e_cyc);
         if (vecs[i].e_cyc) check($sformatf("v%0d adr", i), wb.adr, vecs[i].e_adr);
         check($sformatf("v%0d latch", i), o_data_latch, vecs[i].e_latch);
         check($sformatf("v%0d pcinc", i), o_pc_inc,     vecs[i].e_latch);
         check($sformatf("v%0d busy", i),  o_busy,       vecs[i].e_busy);
         check($sformatf("v%0d err", i),   o_err,        vecs[i].e_err);
         if (vecs[i].e_latch) check($sformatf("v%0d instr", i), o_instruction, vecs[i].dat);
         step();
      end

      // Watchdog: no ack for a whole request.
      i_req = 1'b1;  i_flush = 1'b0;  i_addr = 32'h500;  wb.ack = 1'b0;  wb.err = 1'b0;
      #2;
      cyc_cycles = 0;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         step();
         #2;
         if (wb.cyc) cyc_cycles++;
         else if (cyc_cycles > 0) done = 1'b1;
      end
      check("timeout reached",  done,       1);
      check("timeout cycles",   cyc_cycles, 16);
      check("timeout err",      o_err,      1);
      check("timeout busy",     o_busy,     0);
      saw = 1'b0;
      repeat (3) begin
         step();
         #2;
         if (wb.cyc) saw = 1'b1;
      end
      check("err blocks req", saw, 0);
      step();
      i_flush = 1'b1;
      #2;
      check("err before flush", o_err, 1);
      step();
      i_flush = 1'b0;  i_addr = 32'h600;
      #2;
      check("err cleared",       o_err,  0);
      check("no req on flush",   wb.cyc, 0);
      step();
      #2;
      check("resume cyc", wb.cyc, 1);
      check("resume adr", wb.adr, 32'h600);
      wb.ack = 1'b1;  wb.dat = 32'h12345678;
      #1;
      check("resume latch", o_data_latch,  1);
      check("resume instr", o_instruction, 32'h12345678);
      step();
      wb.ack = 1'b0;  i_req = 1'b0;
      #2;
      check("resume done", wb.cyc, 0);

      // Sticky error cleared by asynchronous reset.
      i_req = 1'b1;  i_addr = 32'h700;
      #2;
      step();
      wb.err = 1'b1;
      #2;
      check("err1 latch", o_data_latch, 0);
      step();
      wb.err = 1'b0;  i_req = 1'b0;
      #2;
      check("err1 flag", o_err, 1);
      i_reset = 1'b1;
      #1;
      check("async err clr", o_err, 0);
      step();
      i_reset = 1'b0;

      // Asynchronous reset in the middle of a request; late ack must be ignored.
      i_req = 1'b1;  i_addr = 32'h700;
      #2;
      check("pre-req cyc", wb.cyc, 0);
      step();
      #2;
      check("mid-req cyc", wb.cyc, 1);
      check("mid-req adr", wb.adr, 32'h700);
      check("mid-req sel", wb.sel, 4'hF);
      #1;
      i_reset = 1'b1;
      #1;
      check("async cyc",  wb.cyc, 0);
      check("async stb",  wb.stb, 0);
      check("async adr",  wb.adr, 0);
      check("async busy", o_busy, 0);
      wb.ack = 1'b1;  wb.dat = 32'hBAD0BAD0;
      #1;
      check("late ack latch", o_data_latch, 0);
      check("late ack pcinc", o_pc_inc,     0);
      step();
      i_reset = 1'b0;  i_req = 1'b0;
      #2;
      check("post-reset latch", o_data_latch, 0);
      check("post-reset cyc",   wb.cyc,       0);
      wb.ack = 1'b0;
      i_req = 1'b1;  i_addr = 32'h800;
      step();
      #2;
      check("final cyc", wb.cyc, 1);
      check("final adr", wb.adr, 32'h800);
      wb.ack = 1'b1;  wb.dat = 32'h00000093;
      #1;
      check("final latch", o_data_latch,  1);
      check("final instr", o_instruction, 32'h00000093);
      step();
      wb.ack = 1'b0;  i_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
